top: RTL and testbench
======================

TOP -- requirements
Module: top

Interface
REQ-001 Parameter WIDTH, default 1: operand and result width in bits; all operations are bitwise.
REQ-002 One clock; reset is asynchronous and active-low.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 A  input  WIDTH  first operand.
REQ-006 B  input  WIDTH  second operand.
REQ-007 Sel  input  4  one-hot operation select.
REQ-008 Y  output  WIDTH  registered logic result.
REQ-009 sel_err  output  1  registered flag: Sel sampled at the same edge was not one-hot.

Function
REQ-010 Operation encoding SHALL be as follows:
- 4'b0001: Y = ~(A & B) (NAND).
- 4'b0010: Y = ~(A | B) (NOR).
- 4'b0100: Y = A ^ B (XOR).
- 4'b1000: Y = ~(A ^ B) (XNOR).
REQ-011 A, B and Sel SHALL be sampled on each rising clk edge, and Y/sel_err SHALL update at that same edge; latency is 1 cycle.
REQ-012 Y SHALL be a pure function of the sampled A, B and Sel, with no dependence on earlier cycles.
REQ-013 Invalid Sel (4'b0000 or more than one bit set):
- Y SHALL load all zeros.
- sel_err SHALL load 1.
REQ-014 Valid Sel SHALL load sel_err with 0.
REQ-015 No combinational path SHALL exist from any input to Y or sel_err.
REQ-016 Y and sel_err SHALL hold their values between rising edges, regardless of input changes.
REQ-017 Operation changes SHALL take effect on the next edge with no bubble or extra latency; back-to-back different ops on consecutive edges SHALL each produce their own result.
REQ-018 For WIDTH>1, each bit i of Y SHALL depend only on A[i] and B[i].

Reset
REQ-019 While rst_n=0, Y SHALL be all zeros and sel_err SHALL be 0, asynchronously and independent of clk.
REQ-020 rst_n assertion in mid-operation SHALL clear the outputs immediately; any in-flight result is discarded.
REQ-021 After rst_n deasserts, the first rising edge SHALL load a normal result computed from the inputs sampled at that edge.
REQ-022 An X or unknown value on A/B SHALL NOT affect the reset values of Y or sel_err.

Verification
REQ-023 Truth table: for Sel in {0001, 0010, 0100, 1000} and all four (A,B) pairs, WIDTH=1, the result one edge later SHALL be:
- NAND: 1,1,1,0
- NOR: 1,0,0,0
- XOR: 0,1,1,0
- XNOR: 1,0,0,1
(pairs in order 00, 01, 10, 11); sel_err=0 throughout.
REQ-024 Invalid select: Sel=0000 and then Sel=0011 with A=1, B=0 -> Y=0 and sel_err=1 after each edge; then Sel=0100 -> Y=1 and sel_err=0.
REQ-025 Latency/hold: A=1, B=1, Sel=0001 at edge n, then A changes to 0 mid-cycle -> Y stays 0 until edge n+1, then becomes 1.
REQ-026 Async reset: with Y=1, drive rst_n=0 between edges -> Y=0 and sel_err=0 before the next edge; release rst_n, A=0, B=0, Sel=1000 -> Y=1 after the first edge.
REQ-027 Random regression: 1000 cycles of random A, B and one-hot Sel -> Y matches a reference model every cycle with 1-cycle latency, and sel_err stays 0.

Source files
------------

// File: rtl/top.sv
// ============================================================================
//  Module      : top
//  Description : Registered bitwise logic unit. A one-hot select picks
//                NAND / NOR / XOR / XNOR of A and B. The result and a
//                select-error flag are registered with one cycle of latency.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module top #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       Sel,
  output logic [WIDTH-1:0] Y,
  output logic             sel_err
);

  // One-hot operation encodings
  localparam logic [3:0] C_OP_NAND = 4'b0001;
  localparam logic [3:0] C_OP_NOR  = 4'b0010;
  localparam logic [3:0] C_OP_XOR  = 4'b0100;
  localparam logic [3:0] C_OP_XNOR = 4'b1000;

  logic [WIDTH-1:0] y_d;
  logic [WIDTH-1:0] y_q;
  logic             err_d;
  logic             err_q;

  // Next-state result: purely a function of the current A, B and Sel.
  // Anything other than exactly one select bit (including all-zero)
  // yields a zero result and raises the error flag.
  always_comb begin
    y_d   = '0;
    err_d = 1'b0;
    case (Sel)
      C_OP_NAND: y_d = ~(A & B);
      C_OP_NOR:  y_d = ~(A | B);
      C_OP_XOR:  y_d = A ^ B;
      C_OP_XNOR: y_d = ~(A ^ B);
      default: begin
        y_d   = '0;
        err_d = 1'b1;
      end
    endcase
  end

  // Output registers; reset clears them immediately, independent of clk
  // and of the operand values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q   <= '0;
      err_q <= 1'b0;
    end else begin
      y_q   <= y_d;
      err_q <= err_d;
    end
  end

  assign Y       = y_q;
  assign sel_err = err_q;

endmodule

`default_nettype wire

// File: tb/tb_top.sv
// ============================================================================
//  Module      : tb_top
//  Description : Directed and random self-checking bench for top (WIDTH=1).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_top;

  localparam int WIDTH = 1;

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [3:0]       Sel;
  logic [WIDTH-1:0] Y;
  logic             sel_err;

  int passed = 0;
  int total  = 0;

  top #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .A       (A),
    .B       (B),
    .Sel     (Sel),
    .Y       (Y),
    .sel_err (sel_err)
  );

  // 10 ns clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare both outputs against expected values
  task automatic chk(input string tag, input logic [WIDTH-1:0] y_exp, input logic e_exp);
    total++;
    assert (Y === y_exp && sel_err === e_exp) passed++;
    else $error("FAIL %s: got Y=%b sel_err=%b, expected Y=%b sel_err=%b",
                tag, Y, sel_err, y_exp, e_exp);
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Independent reference: evaluate the selected operation per bit
  function automatic logic [WIDTH-1:0] ref_y(input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b,
                                             input logic [3:0] s);
    logic [WIDTH-1:0] r;
    for (int i = 0; i < WIDTH; i++) begin
      if      (s == 4'b0001) r[i] = !(a[i] && b[i]);
      else if (s == 4'b0010) r[i] = !(a[i] || b[i]);
      else if (s == 4'b0100) r[i] = (a[i] != b[i]);
      else if (s == 4'b1000) r[i] = (a[i] == b[i]);
      else                   r[i] = 1'b0;
    end
    return r;
  endfunction

  logic [3:0] sels [4];
  logic [3:0] tt   [4];
  logic [1:0] pair;
  logic [3:0] row;
  logic [WIDTH-1:0] exp_y;
  logic [3:0] rs;
  string      tag;

  initial begin
    sels[0] = 4'b0001; tt[0] = 4'b1110; // NAND for pairs 00,01,10,11
    sels[1] = 4'b0010; tt[1] = 4'b1000; // NOR
    sels[2] = 4'b0100; tt[2] = 4'b0110; // XOR
    sels[3] = 4'b1000; tt[3] = 4'b1001; // XNOR

    // Reset held from time 0 with unknown operands
    rst_n = 1'b0;
    A     = 'x;
    B     = 'x;
    Sel   = 4'b0001;
    #2;
    chk("reset_before_edge", '0, 1'b0);
    tick();
    chk("reset_after_edge", '0, 1'b0);

    // Release reset mid-cycle; first edge must load a normal result
    #3;
    rst_n = 1'b1;
    A = 1'b1; B = 1'b1; Sel = 4'b1000;
    tick();
    chk("first_edge_after_reset", 1'b1, 1'b0);

    // Full truth table, one edge per vector
    for (int op = 0; op < 4; op++) begin
      for (int p = 0; p < 4; p++) begin
        pair = p[1:0];
        row  = tt[op];
        A    = pair[1];
        B    = pair[0];
        Sel  = sels[op];
        tick();
        $sformat(tag, "tt_sel%b_ab%b%b", sels[op], pair[1], pair[0]);
        chk(tag, row[3-p], 1'b0);
      end
    end

    // Invalid selects, then recovery
    A = 1'b1; B = 1'b0; Sel = 4'b0000;
    tick();
    chk("invalid_sel_0000", 1'b0, 1'b1);
    Sel = 4'b0011;
    tick();
    chk("invalid_sel_0011", 1'b0, 1'b1);
    Sel = 4'b1111;
    tick();
    chk("invalid_sel_1111", 1'b0, 1'b1);
    Sel = 4'b0100;
    tick();
    chk("valid_after_invalid", 1'b1, 1'b0);

    // Latency / hold: output stays put while inputs change mid-cycle
    A = 1'b1; B = 1'b1; Sel = 4'b0001;
    tick();
    chk("hold_edge_n", 1'b0, 1'b0);
    #2;
    A = 1'b0;
    #1;
    chk("hold_mid_cycle", 1'b0, 1'b0);
    tick();
    chk("hold_edge_n1", 1'b1, 1'b0);

    // Back-to-back op changes on consecutive edges (A=1, B=0)
    A = 1'b1; B = 1'b0;
    Sel = 4'b1000; tick(); chk("b2b_xnor", 1'b0, 1'b0);
    Sel = 4'b0100; tick(); chk("b2b_xor",  1'b1, 1'b0);
    Sel = 4'b0010; tick(); chk("b2b_nor",  1'b0, 1'b0);
    Sel = 4'b0001; tick(); chk("b2b_nand", 1'b1, 1'b0);

    // Async reset mid-cycle with Y=1, operands unknown
    chk("pre_async_reset", 1'b1, 1'b0);
    #2;
    A = 'x; B = 'x;
    rst_n = 1'b0;
    #1;
    chk("async_reset_y", '0, 1'b0);
    #2;
    rst_n = 1'b1;
    A = 1'b0; B = 1'b0; Sel = 4'b1000;
    tick();
    chk("post_async_reset", 1'b1, 1'b0);

    // Async reset clears a raised error flag too
    Sel = 4'b0110;
    tick();
    chk("err_before_reset", 1'b0, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_err", '0, 1'b0);
    #2;
    rst_n = 1'b1;

    // Random regression with one-hot selects
    for (int n = 0; n < 1000; n++) begin
      A  = WIDTH'($urandom);
      B  = WIDTH'($urandom);
      rs = 4'b0001 << $urandom_range(0, 3);
      Sel = rs;
      exp_y = ref_y(A, B, rs);
      tick();
      chk("random", exp_y, 1'b0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
